// File: rtl/aes_pkg.sv
// Shared AES constants and small helpers for the key schedule and the cipher datapath.
// Word indices are 6 bits wide, which covers the AES-128 range of 0..43.
package aes_pkg;

  localparam int NK     = 4;
  localparam int NR     = 10;
  localparam int NWORDS = NK * (NR + 1);
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic {
    ST_IDLE,
    ST_EXPAND
  } state_t;

  // Multiply by x in GF(2^8), reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Bit offset of w[idx] on the expanded-key bus. Round k = idx/4 occupies
  // [128k+127:128k]. The first word of each round sits in the top 32 bits,
  // so ~idx[1:0] (equal to 3 - idx%4) selects the word position in the round.
  function automatic logic [10:0] word_lsb(input logic [5:0] idx);
    return {idx[5:2], 7'd0} + {4'd0, ~idx[1:0], 5'd0};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: one byte in, one substituted byte out.
// The same table serves SubWord here and SubBytes in the cipher.
module aes_sbox (
  input  logic [7:0] plain,
  output logic [7:0] subst
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign subst = SBOX[plain];

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128 key schedule: loads the cipher key, then writes one
// expanded word per clock until all 44 words are on the expanded_key bus.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int KEY_WIDTH  = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [KEY_WIDTH-1:0]            cipher_key,
  output logic [128*(NUM_ROUNDS+1)-1:0]   expanded_key,
  output logic                            busy,
  output logic                            valid
);

  if (KEY_WIDTH != 128 || NUM_ROUNDS != NR) begin : g_bad_config
    $error("aes_key_expander supports only AES-128 (KEY_WIDTH=128, NUM_ROUNDS=10)");
  end

  localparam logic [5:0] LAST_IDX = 6'(NK * (NUM_ROUNDS + 1) - 1);

  state_t                          state_reg;
  logic [5:0]                      idx_reg;
  logic [7:0]                      rcon_reg;
  logic [3:0][31:0]                win_reg;   // w[idx-4] in [0] .. w[idx-1] in [3]
  logic [128*(NUM_ROUNDS+1)-1:0]   exp_reg;
  logic                            busy_reg;
  logic                            valid_reg;

  logic [31:0] rot_word_w;
  logic [31:0] sub_word_w;
  logic [31:0] temp_word;
  logic [31:0] word_next;

  assign rot_word_w = rot_word(win_reg[3]);

  for (genvar gi = 0; gi < 4; gi++) begin : g_subword
    aes_sbox u_sbox (
      .plain (rot_word_w[8*gi +: 8]),
      .subst (sub_word_w[8*gi +: 8])
    );
  end

  always_comb begin
    temp_word = win_reg[3];
    if (idx_reg[1:0] == 2'b00) begin
      temp_word = sub_word_w ^ {rcon_reg, 24'h0};
    end
    word_next = win_reg[0] ^ temp_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      rcon_reg  <= RCON_INIT;
      win_reg   <= '0;
      exp_reg   <= '0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else if (state_reg == ST_IDLE) begin
      if (start) begin
        exp_reg[127:0] <= cipher_key;
        win_reg   <= {cipher_key[31:0], cipher_key[63:32],
                      cipher_key[95:64], cipher_key[127:96]};
        idx_reg   <= 6'd4;
        rcon_reg  <= RCON_INIT;
        busy_reg  <= 1'b1;
        valid_reg <= 1'b0;
        state_reg <= ST_EXPAND;
      end
    end else begin
      exp_reg[word_lsb(idx_reg) +: 32] <= word_next;
      win_reg <= {word_next, win_reg[3:1]};
      idx_reg <= idx_reg + 6'd1;
      if (idx_reg[1:0] == 2'b00) begin
        rcon_reg <= xtime(rcon_reg);
      end
      if (idx_reg == LAST_IDX) begin
        busy_reg  <= 1'b0;
        valid_reg <= 1'b1;
        state_reg <= ST_IDLE;
      end
    end
  end

  assign expanded_key = exp_reg;
  assign busy         = busy_reg;
  assign valid        = valid_reg;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander against a GF(2^8)-derived key schedule model.
`timescale 1ns/1ps
module tb_aes_key_expander;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [127:0]  cipher_key;
  logic [1407:0] expanded_key;
  logic          busy;
  logic          valid;

  aes_key_expander #(.KEY_WIDTH(128), .NUM_ROUNDS(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cipher_key   (cipher_key),
    .expanded_key (expanded_key),
    .busy         (busy),
    .valid        (valid)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  int            errors = 0;
  int            checks = 0;
  int            n;
  int            busy_cnt;
  int            changed;
  int            invalid;
  logic [7:0]    sbox_m [256];
  logic [127:0]  ref_round [11];
  logic [1407:0] snap;
  logic [127:0]  rkey;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then the affine map.
  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox_m[x] = s ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++)
      ref_round[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_keys(input string tag);
    for (int k = 0; k < 11; k++)
      chk($sformatf("%s rk%0d", tag, k), expanded_key[128*k +: 128], ref_round[k]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start, then wait (bounded) for valid; checks latency, busy length and keys.
  task automatic expand_and_check(input logic [127:0] key, input string tag);
    model_expand(key);
    cipher_key = key;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    busy_cnt = busy ? 1 : 0;
    while (!valid && n < 100) begin
      tick();
      n++;
      if (busy) busy_cnt++;
    end
    chk({tag, " latency"}, 128'(n), 128'd41);
    chk({tag, " busy_cycles"}, 128'(busy_cnt), 128'd40);
    check_keys(tag);
    $display("txn %s key=%h latency=%0d rk10=%h", tag, key, n, expanded_key[1407:1280]);
  endtask

  initial begin
    build_sbox();
    rst_n = 1'b0;
    start = 1'b0;
    cipher_key = '0;
    tick();
    tick();
    chk("reset busy", 128'(busy), 128'd0);
    chk("reset valid", 128'(valid), 128'd0);
    for (int k = 0; k < 11; k++) ref_round[k] = '0;
    check_keys("reset");
    rst_n = 1'b1;
    tick();

    // FIPS-197 A.1 key
    expand_and_check(KEY_A1, "a1");
    chk("a1 fips rk1", expanded_key[255:128], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("a1 fips rk10", expanded_key[1407:1280], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // All-zero key
    expand_and_check(128'h0, "zero");
    chk("zero fips rk1", expanded_key[255:128], 128'h62636363626363636263636362636363);
    chk("zero fips rk10", expanded_key[1407:1280], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    chk("zero rk0", expanded_key[127:0], 128'h0);

    // Random keys against the model
    for (int r = 0; r < 4; r++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      expand_and_check(rkey, $sformatf("rand%0d", r));
    end

    // Start while busy must be ignored
    model_expand(KEY_A1);
    cipher_key = KEY_A1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (n < 9) begin tick(); n++; end
    cipher_key = '0;
    start = 1'b1;
    tick();
    n++;
    start = 1'b0;
    while (!valid && n < 100) begin tick(); n++; end
    chk("busy_start latency", 128'(n), 128'd41);
    chk("busy_start rk10", expanded_key[1407:1280], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_keys("busy_start");
    $display("txn busy_start latency=%0d rk10=%h", n, expanded_key[1407:1280]);

    // Reset mid-expansion
    cipher_key = KEY_A1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (n < 20) begin tick(); n++; end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 128'(busy), 128'd0);
    chk("midrst valid", 128'(valid), 128'd0);
    for (int k = 0; k < 11; k++)
      chk($sformatf("midrst rk%0d", k), expanded_key[128*k +: 128], 128'h0);
    $display("txn midrst busy=%0b valid=%0b", busy, valid);
    tick();
    rst_n = 1'b1;
    expand_and_check(KEY_A1, "after_rst");

    // Start held high: one-cycle valid pulse every 41 cycles
    model_expand(KEY_A1);
    cipher_key = KEY_A1;
    start = 1'b1;
    tick();
    n = 1;
    for (int p = 0; p < 3; p++) begin
      while (!valid && n < 100) begin tick(); n++; end
      chk($sformatf("held%0d period", p), 128'(n), 128'd41);
      check_keys($sformatf("held%0d", p));
      tick();
      chk($sformatf("held%0d valid_drop", p), 128'(valid), 128'd0);
      chk($sformatf("held%0d busy_again", p), 128'(busy), 128'd1);
      $display("txn held%0d period=%0d", p, n);
      n = 1;
    end
    start = 1'b0;
    while (!valid && n < 100) begin tick(); n++; end
    chk("held final latency", 128'(n), 128'd41);

    // cipher_key changes without start must not disturb the result
    snap = expanded_key;
    changed = 0;
    invalid = 0;
    for (int c = 0; c < 100; c++) begin
      cipher_key = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (expanded_key !== snap) changed++;
      if (valid !== 1'b1) invalid++;
    end
    chk("stable changed_cycles", 128'(changed), 128'd0);
    chk("stable invalid_cycles", 128'(invalid), 128'd0);
    check_keys("stable");
    $display("txn stable changed=%0d invalid=%0d", changed, invalid);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
